// File: rtl/vc_control.sv
// Victim-cache tag store sequencer: probe compare, hit-swap/victim install, hit/way response to L1.
// Latency: request to vc_resp is 2 cycles without an evicted line, 3 with one. Optional VC_LRU_EN selects true LRU.
// Backpressure: one probe in flight; vc_busy stays high until the cycle after vc_resp, and requests seen while busy are ignored.
module vc_control #(
    parameter int tag_width        = 24,
    parameter int vc_size          = 8,
    parameter int num_mux_sel_bits = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        l1_vc_req,
    input  logic [tag_width-1:0]        l1_miss_tag,
    input  logic                        l1_evict_valid,
    input  logic [tag_width-1:0]        l1_evict_tag,
    output logic                        vc_busy,
    output logic                        vc_resp,
    output logic                        vc_hit,
    output logic [num_mux_sel_bits-1:0] vc_hit_way,
    output logic                        vc_tag_cmp,
    output logic                        vc_tag_write,
    output logic [vc_size-1:0]          vc_tag_store_ld_mask,
    output logic [tag_width-1:0]        vc_tag_store_datain,
    input  logic [num_mux_sel_bits-1:0] vc_datamux_sel,
    output logic                        vc_data_write,
    output logic [num_mux_sel_bits-1:0] vc_data_way
);
    localparam int ptr_w = $clog2(vc_size);

    typedef enum logic [1:0] {IDLE, CMP, INSERT, RESP} state_t;

    state_t               state;
    logic                 evict_valid_q;
    logic [tag_width-1:0] evict_tag_q;
    logic [vc_size-1:0]   valid;
    logic [ptr_w-1:0]     target_q;

    logic                 sel_in_range;
    logic [ptr_w-1:0]     sel_idx;
    logic                 cmp_hit;
    logic                 free_found;
    logic [ptr_w-1:0]     free_way;
    logic [ptr_w-1:0]     repl_way;
    logic [ptr_w-1:0]     cmp_target;

`ifdef VC_LRU_EN
    typedef logic [vc_size-1:0][ptr_w-1:0] age_t;
    age_t age;

    // Promote way w to age 0; only ways younger than its old age get older.
    function automatic age_t lru_touch(input age_t a, input logic [ptr_w-1:0] w);
        age_t r;
        r = a;
        for (int i = 0; i < vc_size; i++) begin
            if (ptr_w'(i) == w)
                r[i] = '0;
            else if (a[i] < a[w])
                r[i] = a[i] + 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        repl_way = '0;
        for (int i = 0; i < vc_size; i++) begin
            if (valid[i] && age[i] == ptr_w'(vc_size - 1))
                repl_way = ptr_w'(i);
        end
    end
`else
    logic [ptr_w-1:0] rr_ptr;
    logic             replace_q;

    always_comb repl_way = rr_ptr;
`endif

    always_comb begin
        sel_in_range = vc_datamux_sel < num_mux_sel_bits'(vc_size);
        sel_idx      = vc_datamux_sel[ptr_w-1:0];
        cmp_hit      = sel_in_range && valid[sel_idx];
        free_found   = 1'b0;
        free_way     = '0;
        for (int i = vc_size - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_way   = ptr_w'(i);
            end
        end
        if (cmp_hit)
            cmp_target = sel_idx;
        else if (free_found)
            cmp_target = free_way;
        else
            cmp_target = repl_way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            evict_valid_q        <= 1'b0;
            evict_tag_q          <= '0;
            valid                <= '0;
            target_q             <= '0;
            vc_busy              <= 1'b0;
            vc_resp              <= 1'b0;
            vc_hit               <= 1'b0;
            vc_hit_way           <= '0;
            vc_tag_cmp           <= 1'b0;
            vc_tag_write         <= 1'b0;
            vc_data_write        <= 1'b0;
            vc_tag_store_ld_mask <= '0;
            vc_tag_store_datain  <= '0;
            vc_data_way          <= '0;
`ifdef VC_LRU_EN
            for (int i = 0; i < vc_size; i++)
                age[i] <= ptr_w'(i);
`else
            rr_ptr               <= '0;
            replace_q            <= 1'b0;
`endif
        end else begin
            vc_resp              <= 1'b0;
            vc_tag_cmp           <= 1'b0;
            vc_tag_write         <= 1'b0;
            vc_data_write        <= 1'b0;
            vc_tag_store_ld_mask <= '0;
            case (state)
                IDLE: begin
                    if (l1_vc_req) begin
                        state               <= CMP;
                        evict_valid_q       <= l1_evict_valid;
                        evict_tag_q         <= l1_evict_tag;
                        vc_busy             <= 1'b1;
                        vc_tag_cmp          <= 1'b1;
                        vc_tag_store_datain <= l1_miss_tag;
                    end
                end
                CMP: begin
                    vc_hit     <= cmp_hit;
                    vc_hit_way <= cmp_hit ? vc_datamux_sel : '0;
                    target_q   <= cmp_target;
                    if (cmp_hit)
                        vc_data_way <= vc_datamux_sel;
`ifdef VC_LRU_EN
                    if (cmp_hit)
                        age <= lru_touch(age, sel_idx);
`else
                    replace_q <= !cmp_hit && !free_found;
`endif
                    if (evict_valid_q) begin
                        state                <= INSERT;
                        vc_tag_write         <= 1'b1;
                        vc_data_write        <= 1'b1;
                        vc_tag_store_ld_mask <= vc_size'(1) << cmp_target;
                        vc_tag_store_datain  <= evict_tag_q;
                        vc_data_way          <= num_mux_sel_bits'(cmp_target);
                    end else begin
                        state   <= RESP;
                        vc_resp <= 1'b1;
                        // Exclusive hierarchy: the hit line now lives only in L1.
                        if (cmp_hit)
                            valid[sel_idx] <= 1'b0;
                    end
                end
                INSERT: begin
                    state           <= RESP;
                    vc_resp         <= 1'b1;
                    valid[target_q] <= 1'b1;
`ifdef VC_LRU_EN
                    age <= lru_touch(age, target_q);
`else
                    if (replace_q)
                        rr_ptr <= (rr_ptr == ptr_w'(vc_size - 1)) ? '0 : rr_ptr + 1'b1;
`endif
                end
                RESP: begin
                    state   <= IDLE;
                    vc_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_control.sv
// Self-checking bench for vc_control: behavioural tag store plus a way/recency reference model.
module tb_vc_control;
    localparam int TW = 24;
    localparam int VS = 8;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          l1_vc_req;
    logic [TW-1:0] l1_miss_tag;
    logic          l1_evict_valid;
    logic [TW-1:0] l1_evict_tag;
    logic          vc_busy, vc_resp, vc_hit, vc_tag_cmp, vc_tag_write, vc_data_write;
    logic [SB-1:0] vc_hit_way, vc_datamux_sel, vc_data_way;
    logic [VS-1:0] vc_tag_store_ld_mask;
    logic [TW-1:0] vc_tag_store_datain;

    vc_control #(.tag_width(TW), .vc_size(VS), .num_mux_sel_bits(SB)) dut (
        .clk(clk), .rst(rst),
        .l1_vc_req(l1_vc_req), .l1_miss_tag(l1_miss_tag),
        .l1_evict_valid(l1_evict_valid), .l1_evict_tag(l1_evict_tag),
        .vc_busy(vc_busy), .vc_resp(vc_resp), .vc_hit(vc_hit), .vc_hit_way(vc_hit_way),
        .vc_tag_cmp(vc_tag_cmp), .vc_tag_write(vc_tag_write),
        .vc_tag_store_ld_mask(vc_tag_store_ld_mask), .vc_tag_store_datain(vc_tag_store_datain),
        .vc_datamux_sel(vc_datamux_sel), .vc_data_write(vc_data_write), .vc_data_way(vc_data_way)
    );

    always #5 clk = ~clk;

    // Tag store: no valid bits, tags power up as zero, lowest matching way wins.
    logic [TW-1:0] ts [VS] = '{default: '0};
    always @(posedge clk) begin
        if (vc_tag_write)
            for (int i = 0; i < VS; i++)
                if (vc_tag_store_ld_mask[i]) ts[i] <= vc_tag_store_datain;
    end
    always_comb begin
        vc_datamux_sel = SB'(VS);
        for (int i = VS - 1; i >= 0; i--)
            if (ts[i] == vc_tag_store_datain) vc_datamux_sel = SB'(i);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which tag sits valid in which way, plus replacement order.
    bit            m_valid [VS];
    logic [TW-1:0] m_tag   [VS];
    int            m_rr;
    int            m_lru [$];   // way indices, most recently used first

    task automatic model_reset();
        for (int i = 0; i < VS; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        m_lru = {};
        for (int i = 0; i < VS; i++) m_lru.push_back(i);
    endtask

    task automatic model_touch(input int w);
        for (int i = 0; i < m_lru.size(); i++)
            if (m_lru[i] == w) begin
                m_lru.delete(i);
                break;
            end
        m_lru.push_front(w);
    endtask

    task automatic check_valid(input string tag);
        logic [VS-1:0] p;
        for (int i = 0; i < VS; i++) p[i] = m_valid[i];
        chk(tag, 32'(dut.valid), 32'(p));
    endtask

    task automatic probe(input logic [TW-1:0] mt, input bit ev, input logic [TW-1:0] et, input bit abort);
        bit   ehit, full, got_resp, wr_seen, leak, r_hit, w_dwr;
        int   eway, tgt, lat, g;
        logic [SB-1:0] r_way, w_dway;
        logic [VS-1:0] w_mask;
        logic [TW-1:0] w_dat;
        ehit = 0; eway = 0; full = 1; tgt = -1;
        for (int w = 0; w < VS; w++)
            if (m_valid[w] && m_tag[w] == mt) begin ehit = 1; eway = w; end
        for (int w = VS - 1; w >= 0; w--)
            if (!m_valid[w]) begin full = 0; tgt = w; end
        if (ehit) tgt = eway;
        else if (full) begin
`ifdef VC_LRU_EN
            tgt = m_lru[VS-1];
`else
            tgt = m_rr;
`endif
        end

        g = 0;
        while (vc_busy && g < 20) begin @(negedge clk); g++; end
        chk("idle_before_req", 32'(vc_busy), 0);
        l1_vc_req = 1; l1_miss_tag = mt; l1_evict_valid = ev; l1_evict_tag = et;
        @(negedge clk);
        l1_vc_req = 0; l1_evict_valid = $urandom_range(0, 1); l1_evict_tag = TW'($urandom);
        chk("cmp_busy", 32'(vc_busy), 1);
        chk("cmp_strobe", 32'(vc_tag_cmp), 1);
        chk("cmp_datain", 32'(vc_tag_store_datain), 32'(mt));

        if (abort) begin
            @(negedge clk);
            chk("abort_in_insert", 32'(vc_tag_write), 1);
            rst = 1;
            @(negedge clk);
            rst = 0;
            chk("abort_no_resp", 32'(vc_resp), 0);
            chk("abort_busy", 32'(vc_busy), 0);
            model_reset();
            check_valid("abort_valid");
            return;
        end

        got_resp = 0; wr_seen = 0; leak = 0; lat = 0; r_hit = 0; r_way = 0;
        w_mask = 0; w_dat = 0; w_dwr = 0; w_dway = 0;
        for (int c = 2; c <= 6 && !got_resp; c++) begin
            @(negedge clk);
            if (vc_tag_write) begin
                wr_seen = 1; w_mask = vc_tag_store_ld_mask; w_dat = vc_tag_store_datain;
                w_dwr = vc_data_write; w_dway = vc_data_way;
            end else if (vc_tag_store_ld_mask != 0) leak = 1;
            if (vc_resp) begin got_resp = 1; lat = c; r_hit = vc_hit; r_way = vc_hit_way; end
        end
        chk("resp_latency", 32'(lat), ev ? 3 : 2);
        chk("resp_hit", 32'(r_hit), 32'(ehit));
        if (ehit) chk("resp_hit_way", 32'(r_way), 32'(eway));
        chk("insert_seen", 32'(wr_seen), 32'(ev));
        chk("ld_mask_only_on_write", 32'(leak), 0);
        if (ev) begin
            chk("insert_mask", 32'(w_mask), 32'(1) << tgt);
            chk("insert_tag", 32'(w_dat), 32'(et));
            chk("insert_data_write", 32'(w_dwr), 1);
            chk("insert_data_way", 32'(w_dway), 32'(tgt));
        end
        @(negedge clk);
        chk("busy_after_resp", 32'(vc_busy), 0);
        chk("resp_one_cycle", 32'(vc_resp), 0);

        if (ehit) model_touch(eway);
        if (ev) begin
            if (!ehit && full) m_rr = (m_rr + 1) % VS;
            m_tag[tgt] = et;
            m_valid[tgt] = 1;
            model_touch(tgt);
        end else if (ehit) m_valid[eway] = 0;
        check_valid("valid_bits");
    endtask

    initial begin
        logic [TW-1:0] mt, et_ctr;
        bit ev;
        rst = 1; l1_vc_req = 0; l1_miss_tag = 0; l1_evict_valid = 0; l1_evict_tag = 0;
        for (int i = 0; i < VS; i++) m_tag[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(vc_busy), 0);
        chk("rst_resp", 32'(vc_resp), 0);
        chk("rst_hit", 32'(vc_hit), 0);
        chk("rst_hit_way", 32'(vc_hit_way), 0);
        chk("rst_cmp", 32'(vc_tag_cmp), 0);
        chk("rst_twr", 32'(vc_tag_write), 0);
        chk("rst_dwr", 32'(vc_data_write), 0);
        chk("rst_mask", 32'(vc_tag_store_ld_mask), 0);
        chk("rst_datain", 32'(vc_tag_store_datain), 0);
        chk("rst_data_way", 32'(vc_data_way), 0);
        check_valid("rst_valid");
        rst = 0;
        @(negedge clk);

        probe(24'h000000, 0, 24'h0, 0);
        for (int i = 0; i < VS; i++) probe(24'h10 + TW'(i), 1, 24'h10 + TW'(i), 0);
        probe(24'h13, 1, 24'h20, 0);
        probe(24'h20, 0, 24'h0, 0);
        probe(24'h20, 0, 24'h0, 0);
        probe(24'h40, 1, 24'h21, 0);
        probe(24'h41, 1, 24'h30, 0);
        probe(24'h42, 1, 24'h31, 0);
        // Hit ways 0..6 in order so way 7 becomes least recently used.
        for (int w = 0; w < VS - 1; w++) probe(m_tag[w], 1, 24'h50 + TW'(w), 0);
        probe(24'h43, 1, 24'h60, 0);

        et_ctr = 24'h000100;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 1) mt = m_tag[$urandom_range(0, VS - 1)];
            else mt = {8'h80, 16'($urandom)};
            ev = ($urandom_range(0, 9) < 7);
            probe(mt, ev, et_ctr, 0);
            et_ctr++;
        end

        probe(24'h44, 1, et_ctr, 1);
        et_ctr++;
        for (int n = 0; n < 10; n++) begin
            probe({8'h81, 16'($urandom)}, 1, et_ctr, 0);
            et_ctr++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vc_control.md
# vc_control

Sequencing controller for the victim cache tag store. It accepts one L1-miss probe at a time, carrying the missed tag and an optional evicted L1 line. It drives the tag store compare and write strobes, and on a hit swaps the victim-cache line with the L1 victim. On a miss it installs the L1 victim into a free or replaced way and returns hit/way to the L1 miss handler. It sits between the L1 controller and the victim-cache tag/data stores, and owns the per-way valid bits, which the tag store does not keep.

## Interface
- `tag_width`, 24, tag bits per line
- `vc_size`, 8, number of victim-cache ways
- `num_mux_sel_bits`, 4, width of way select; the tag store reports a miss as value `vc_size` (4'b1000)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `l1_vc_req`  in  1  probe request; sampled only in IDLE
- `l1_miss_tag`  in  tag_width  tag being looked up
- `l1_evict_valid`  in  1  L1 has a victim line to hand over
- `l1_evict_tag`  in  tag_width  tag of L1 victim
- `vc_busy`  out  1  high in every state except IDLE
- `vc_resp`  out  1  one-cycle result pulse
- `vc_hit`  out  1  hit flag, valid while `vc_resp`
- `vc_hit_way`  out  num_mux_sel_bits  hit way, valid while `vc_resp && vc_hit`
- `vc_tag_cmp`  out  1  tag store compare enable
- `vc_tag_write`  out  1  tag store write enable
- `vc_tag_store_ld_mask`  out  vc_size  one-hot write way
- `vc_tag_store_datain`  out  tag_width  compare or write tag
- `vc_datamux_sel`  in  num_mux_sel_bits  tag store match result
- `vc_data_write`  out  1  data store write strobe, same cycle as `vc_tag_write`
- `vc_data_way`  out  num_mux_sel_bits  data store read/write way

## Operation
- FSM states: IDLE, CMP, INSERT, RESP. Reset enters IDLE.
- **IDLE**
  - On `l1_vc_req`, register `l1_miss_tag`, `l1_evict_valid` and `l1_evict_tag`, then go to CMP.
  - Requests arriving in other states are ignored. The requester must wait for `vc_busy`=0.
- **CMP**
  - Drive `vc_tag_cmp`=1 and `vc_tag_store_datain`=captured miss tag.
  - Hit = `vc_datamux_sel < vc_size && valid[vc_datamux_sel]`. A match on an invalid way is a miss.
  - Register hit and way, and drive `vc_data_way`=sel on a hit so the line can be read.
  - Choose the target way:
    - hit: the hit way.
    - miss, some way invalid: the lowest-index invalid way.
    - miss, all ways valid: the replacement way.
  - Next state is INSERT if `evict_valid`, else RESP.
  - Hit without an evicted line: clear `valid[hit_way]` at the end of CMP, since the line moves to L1 (exclusive).
- **INSERT**
  - Drive `vc_tag_write`=1, `vc_data_write`=1, `ld_mask` = one-hot(target), `datain`=captured evict tag, `vc_data_way`=target.
  - Set `valid[target]`, update replacement state, then go to RESP.
- **RESP**: `vc_resp`=1 with registered `vc_hit`/`vc_hit_way`, then go to IDLE.
- **Requester rule**: the evicted tag never duplicates a valid victim-cache tag. L1 and the victim cache are exclusive. The controller does not check this.
- **Default replacement**: round-robin pointer of clog2(`vc_size`) bits.
  - Advances (wrapping `vc_size-1`→0) only on an INSERT that replaces a valid way.
  - Filling an invalid way or a hit-swap leaves it unchanged.
- **Reset mid-operation**: return to IDLE, clear all valid bits and the pointer, drop the pending request with no `vc_resp`.

## Timing
- Reset values:
  - `vc_busy`, `vc_resp`, `vc_hit`, `vc_tag_cmp`, `vc_tag_write`, `vc_data_write` = 0.
  - `ld_mask`, `datain`, `vc_hit_way`, `vc_data_way` = 0.
  - valid = 0, pointer = 0.
- Request accepted in cycle 0, CMP in cycle 1, then:
  - with an evicted line: INSERT in cycle 2, `vc_resp` in cycle 3 (latency 3);
  - without an evicted line: `vc_resp` in cycle 2 (latency 2).
- `vc_busy` rises in the cycle after acceptance and falls in the cycle after RESP. The earliest next acceptance is the cycle after RESP.
- `vc_datamux_sel` is combinational from the tag store and is sampled at the end of CMP.
- `ld_mask` is nonzero only while `vc_tag_write`=1.

## Configuration
- **`VC_LRU_EN` defined**
  - True LRU replaces round-robin: per-way age counters of clog2(`vc_size`) bits.
  - A hit or an INSERT makes the target way MRU (age 0); ages younger than the old age of that way increment.
  - The replacement way is the valid way with age `vc_size-1`.
  - Reset ages: way i = i.
- **Undefined**: the round-robin pointer described above.

## Test plan
- **Reset then probe**: reset; probe tag 0x000000 with no evict → `vc_resp` at cycle 2, `vc_hit`=0, because the reset-zero tags are invalid.
- **Fill**: 8 probes with miss and evict tags 0x10..0x17 → installed in ways 0..7 in order, each `vc_resp` at cycle 3, valid = 0xFF.
- **Hit-swap**: probe miss tag 0x13 with evict 0x20 → `vc_hit`=1, `vc_hit_way`=3, INSERT writes 0x20 into way 3 (`ld_mask`=0x08).
- **Hit without evict**: then probe 0x20 with no evict → hit way 3, valid[3] clears, and a following probe of 0x20 misses.
- **Replacement, full cache**:
  - Round-robin: a miss with evict 0x30 writes way 0, the next writes way 1.
  - With `VC_LRU_EN`, after hits on ways 0..6, the next insert writes way 7.
- **Reset mid-operation**: assert `rst` during INSERT → no `vc_resp`, `vc_busy`=0 the next cycle, valid = 0.
